uart_fifo_core: RTL

Parametrised UART transceiver with independent TX and RX FIFOs, configurable frame format and line-error detection. It replaces the fixed 8N1, unbuffered TX/RX pair on the CPU's serial terminal path. The CPU and file-store logic can queue output bursts (string ROM dumps, file read-back) and absorb typed input without dropping characters. Sits between the core's I/O instruction logic and the `uart_rx`/`uart_tx` pins.

---
 rtl/uart_fifo_core_if.sv | 33 +++
 rtl/uart_fifo_core.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_fifo_core_if.sv
// CPU-side bundle for uart_fifo_core: TX push port, RX pop port and
// sticky line-error flags.
interface uart_fifo_core_if #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_wr;
    logic                 tx_full;
    logic                 tx_idle;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_rd;
    logic                 rx_empty;
    logic [LW-1:0]        rx_level;
    logic                 frame_err;
    logic                 parity_err;
    logic                 overrun;
    logic                 err_clr;

    modport master (
        output tx_data, tx_wr, rx_rd, err_clr,
        input  tx_full, tx_idle, rx_data, rx_empty, rx_level,
        input  frame_err, parity_err, overrun
    );

    modport slave (
        input  tx_data, tx_wr, rx_rd, err_clr,
        output tx_full, tx_idle, rx_data, rx_empty, rx_level,
        output frame_err, parity_err, overrun
    );
endinterface

// File: rtl/uart_fifo_core.sv
// Buffered UART: TX FIFO feeding a serialiser, deserialiser feeding an
// RX FIFO, configurable data/parity/stop format, sticky error flags.
module uart_fifo_core #(
    parameter int CLKS_PER_BIT = 1250,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic            clk,
    input  logic            rst,
    uart_fifo_core_if.slave bus,
    input  logic            uart_rx,
    output logic            uart_tx
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_END   = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] MID       = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0]    LAST_BIT  = 3'(DATA_BITS - 1);
    localparam logic          LAST_STOP = 1'(STOP_BITS - 1);
    localparam logic [LW-1:0] FULL      = LW'(FIFO_DEPTH);
    localparam logic          PAR_ODD   = (PARITY == 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PAR, S_STOP
    } state_t;

    // ---------------- TX FIFO ----------------
    logic [DATA_BITS-1:0] tx_mem [FIFO_DEPTH];
    logic [AW-1:0]        tx_wp, tx_rp;
    logic [LW-1:0]        tx_cnt;
    logic                 tx_push, tx_pop, tx_empty;

    assign tx_empty    = (tx_cnt == '0);
    assign bus.tx_full = (tx_cnt == FULL);
    assign tx_push     = bus.tx_wr && !bus.tx_full;

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wp] <= bus.tx_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_wp  <= '0;
            tx_rp  <= '0;
            tx_cnt <= '0;
        end else begin
            if (tx_push) tx_wp <= tx_wp + AW'(1);
            if (tx_pop)  tx_rp <= tx_rp + AW'(1);
            tx_cnt <= tx_cnt + LW'(tx_push) - LW'(tx_pop);
        end
    end

    // ---------------- TX engine ----------------
    state_t               tx_st;
    logic [CW-1:0]        tx_tick;
    logic [2:0]           tx_bit;
    logic                 tx_stop;
    logic [DATA_BITS-1:0] tx_sh;
    logic                 tx_par;
    logic                 tx_end;

    assign tx_end = (tx_tick == BIT_END);
    // Reloading on the last stop cycle keeps bursts gap-free.
    assign tx_pop = !tx_empty &&
                    ((tx_st == S_IDLE) ||
                     (tx_st == S_STOP && tx_end && tx_stop == LAST_STOP));

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_st       <= S_IDLE;
            tx_tick     <= '0;
            tx_bit      <= '0;
            tx_stop     <= 1'b0;
            tx_sh       <= '0;
            tx_par      <= 1'b0;
            uart_tx     <= 1'b1;
            bus.tx_idle <= 1'b1;
        end else begin
            bus.tx_idle <= tx_empty && (tx_st == S_IDLE);
            unique case (tx_st)
                S_START: uart_tx <= 1'b0;
                S_DATA:  uart_tx <= tx_sh[0];
                S_PAR:   uart_tx <= tx_par;
                default: uart_tx <= 1'b1;
            endcase
            if (tx_pop) begin
                tx_st   <= S_START;
                tx_sh   <= tx_mem[tx_rp];
                tx_par  <= (^tx_mem[tx_rp]) ^ PAR_ODD;
                tx_tick <= '0;
            end else if (tx_st != S_IDLE) begin
                if (!tx_end) begin
                    tx_tick <= tx_tick + CW'(1);
                end else begin
                    tx_tick <= '0;
                    unique case (tx_st)
                        S_START: begin
                            tx_st  <= S_DATA;
                            tx_bit <= '0;
                        end
                        S_DATA: begin
                            tx_sh  <= tx_sh >> 1;
                            tx_bit <= tx_bit + 3'd1;
                            if (tx_bit == LAST_BIT) begin
                                tx_st   <= (PARITY != 0) ? S_PAR : S_STOP;
                                tx_stop <= 1'b0;
                            end
                        end
                        S_PAR: begin
                            tx_st   <= S_STOP;
                            tx_stop <= 1'b0;
                        end
                        default: begin
                            tx_stop <= tx_stop + 1'b1;
                            if (tx_stop == LAST_STOP) tx_st <= S_IDLE;
                        end
                    endcase
                end
            end
        end
    end

    // ---------------- RX engine ----------------
    logic                 rx_s1, rx_s2, rx_s3;
    state_t               rx_st;
    logic [CW-1:0]        rx_tick;
    logic [2:0]           rx_bit;
    logic [DATA_BITS-1:0] rx_sh;
    logic                 rx_pbit;
    logic                 rx_done, rx_bad_stop, rx_bad_par;
    logic                 rx_end;

    assign rx_end = (rx_tick == BIT_END);

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_s3 <= 1'b1;
        end else begin
            rx_s1 <= uart_rx;
            rx_s2 <= rx_s1;
            rx_s3 <= rx_s2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_st       <= S_IDLE;
            rx_tick     <= '0;
            rx_bit      <= '0;
            rx_sh       <= '0;
            rx_pbit     <= 1'b0;
            rx_done     <= 1'b0;
            rx_bad_stop <= 1'b0;
            rx_bad_par  <= 1'b0;
        end else begin
            rx_done <= 1'b0;
            unique case (rx_st)
                S_IDLE: begin
                    if (rx_s3 && !rx_s2) begin
                        rx_st   <= S_START;
                        rx_tick <= '0;
                    end
                end
                S_START: begin
                    if (rx_tick == MID) begin
                        rx_tick <= '0;
                        rx_bit  <= '0;
                        rx_st   <= rx_s2 ? S_IDLE : S_DATA;
                    end else begin
                        rx_tick <= rx_tick + CW'(1);
                    end
                end
                S_DATA: begin
                    if (rx_end) begin
                        rx_tick <= '0;
                        rx_sh   <= {rx_s2, rx_sh[DATA_BITS-1:1]};
                        rx_bit  <= rx_bit + 3'd1;
                        if (rx_bit == LAST_BIT)
                            rx_st <= (PARITY != 0) ? S_PAR : S_STOP;
                    end else begin
                        rx_tick <= rx_tick + CW'(1);
                    end
                end
                S_PAR: begin
                    if (rx_end) begin
                        rx_tick <= '0;
                        rx_pbit <= rx_s2;
                        rx_st   <= S_STOP;
                    end else begin
                        rx_tick <= rx_tick + CW'(1);
                    end
                end
                default: begin
                    if (rx_end) begin
                        rx_tick     <= '0;
                        rx_st       <= S_IDLE;
                        rx_done     <= 1'b1;
                        rx_bad_stop <= !rx_s2;
                        rx_bad_par  <= (PARITY != 0) &&
                                       ((^rx_sh ^ rx_pbit) != PAR_ODD);
                    end else begin
                        rx_tick <= rx_tick + CW'(1);
                    end
                end
            endcase
        end
    end

    // ---------------- RX FIFO and flags ----------------
    logic [DATA_BITS-1:0] rx_mem [FIFO_DEPTH];
    logic [AW-1:0]        rx_wp, rx_rp;
    logic [LW-1:0]        rx_cnt;
    logic                 rx_req, rx_push, rx_pop, rx_full;

    assign rx_full      = (rx_cnt == FULL);
    assign rx_req       = rx_done && !rx_bad_stop;
    assign rx_pop       = bus.rx_rd && !bus.rx_empty;
    assign rx_push      = rx_req && (!rx_full || rx_pop);
    assign bus.rx_empty = (rx_cnt == '0);
    assign bus.rx_level = rx_cnt;
    assign bus.rx_data  = rx_mem[rx_rp];

    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wp] <= rx_sh;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_wp          <= '0;
            rx_rp          <= '0;
            rx_cnt         <= '0;
            bus.frame_err  <= 1'b0;
            bus.parity_err <= 1'b0;
            bus.overrun    <= 1'b0;
        end else begin
            if (rx_push) rx_wp <= rx_wp + AW'(1);
            if (rx_pop)  rx_rp <= rx_rp + AW'(1);
            rx_cnt <= rx_cnt + LW'(rx_push) - LW'(rx_pop);
            // A new event wins over a coincident clear.
            bus.frame_err  <= (bus.frame_err && !bus.err_clr) ||
                              (rx_done && rx_bad_stop);
            bus.parity_err <= (bus.parity_err && !bus.err_clr) ||
                              (rx_req && rx_bad_par);
            bus.overrun    <= (bus.overrun && !bus.err_clr) ||
                              (rx_req && rx_full && !rx_pop);
        end
    end
endmodule
